// File: rtl/decoder_pkg.sv
// Constants and elaboration-time helpers shared by the min-sum decoder layers.
package decoder_pkg;

    // Level of the asynchronous reset input that holds state in reset.
    localparam logic RESET_VAL = 1'b0;

    localparam int unsigned DEF_WIDTH = 8;
    localparam int unsigned DEF_N_V   = 44;
    localparam int unsigned DEF_N_C   = 22;
    localparam int unsigned DEF_E     = 132;

    typedef enum logic [0:0] {
        StIdle,
        StFill
    } wr_state_e;

    function automatic int unsigned ceil_div(input int unsigned a, input int unsigned b);
        return (a + b - 1) / b;
    endfunction

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        int unsigned x;
        r = 0;
        x = 1;
        while (x < v) begin
            x = x << 1;
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/llr_sat.sv
// Single-lane LLR saturator: clips a two's-complement value to [-LLR_MAX, +LLR_MAX],
// so the most negative code never reaches the decoder.
module llr_sat #(
    parameter int unsigned WIDTH   = 8,
    parameter int          LLR_MAX = 127
) (
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    localparam logic signed [WIDTH-1:0] POS = WIDTH'(LLR_MAX);
    localparam logic signed [WIDTH-1:0] NEG = -POS;

    logic signed [WIDTH-1:0] din_s;

    assign din_s = signed'(din);

    always_comb begin
        dout = din;
        if (din_s > POS) begin
            dout = POS;
        end else if (din_s < NEG) begin
            dout = NEG;
        end
    end

endmodule

// File: rtl/llr_frame_loader.sv
// Double-buffered LLR frame deserialiser feeding the decoder core.
// Optional per-lane input saturation is enabled by defining LLR_SAT_EN.
module llr_frame_loader
    import decoder_pkg::*;
#(
    parameter int unsigned WIDTH   = DEF_WIDTH,
    parameter int unsigned N_LLRS  = 4,
    parameter int unsigned N_V     = DEF_N_V,
    parameter int unsigned CNT_W   = 16,
    parameter int          LLR_MAX = 2 ** (WIDTH - 1) - 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_LLRS*WIDTH-1:0] llr,
    input  logic                    first_data,
    input  logic                    data_valid,
    output logic                    data_ready,
    output logic [N_V*WIDTH-1:0]    frame_data,
    output logic                    frame_valid,
    input  logic                    frame_ready,
    output logic                    sync_err,
    output logic [CNT_W-1:0]        frame_cnt
);

    localparam int unsigned BEATS  = ceil_div(N_V, N_LLRS);
    localparam int unsigned BCNT_W = (BEATS > 1) ? clog2(BEATS) : 1;
    localparam logic [BCNT_W-1:0] LAST_BEAT = BCNT_W'(BEATS - 1);

    logic [N_LLRS*WIDTH-1:0] lanes;

    for (genvar k = 0; k < N_LLRS; k++) begin : g_lane
`ifdef LLR_SAT_EN
        llr_sat #(
            .WIDTH   (WIDTH),
            .LLR_MAX (LLR_MAX)
        ) u_llr_sat (
            .din  (llr[k*WIDTH +: WIDTH]),
            .dout (lanes[k*WIDTH +: WIDTH])
        );
`else
        assign lanes[k*WIDTH +: WIDTH] = llr[k*WIDTH +: WIDTH];
`endif
    end

    wr_state_e            state_q, state_d;
    logic [BCNT_W-1:0]    bcnt_q, bcnt_d;
    logic [N_V*WIDTH-1:0] frame_buf_q [2];
    logic [N_V*WIDTH-1:0] frame_buf_d [2];
    logic [1:0]           full_q, full_d;
    logic                 wp_q, wp_d;
    logic                 rp_q, rp_d;
    logic [CNT_W-1:0]     frame_cnt_q, frame_cnt_d;
    logic                 sync_err_q, sync_err_d;

    logic              accept;
    logic              consume;
    logic              wr_en;
    logic              complete;
    logic [BCNT_W-1:0] wr_idx;

    assign data_ready  = !full_q[wp_q];
    assign frame_valid = full_q[rp_q];
    assign frame_data  = frame_buf_q[rp_q];
    assign sync_err    = sync_err_q;
    assign frame_cnt   = frame_cnt_q;

    assign accept  = data_valid && data_ready;
    assign consume = frame_valid && frame_ready;

    // Write-side FSM: a first_data beat always restarts assembly at beat 0.
    always_comb begin
        state_d    = state_q;
        bcnt_d     = bcnt_q;
        wr_en      = 1'b0;
        wr_idx     = bcnt_q;
        sync_err_d = 1'b0;
        if (accept) begin
            if (first_data) begin
                wr_en      = 1'b1;
                wr_idx     = '0;
                sync_err_d = (state_q == StFill);
            end else if (state_q == StFill) begin
                wr_en = 1'b1;
            end else begin
                sync_err_d = 1'b1;
            end
        end
        complete = wr_en && (wr_idx == LAST_BEAT);
        if (wr_en) begin
            if (complete) begin
                state_d = StIdle;
                bcnt_d  = '0;
            end else begin
                state_d = StFill;
                bcnt_d  = wr_idx + BCNT_W'(1);
            end
        end
    end

    // Lanes of the last beat that fall past N_V never match a node and are dropped.
    always_comb begin
        frame_buf_d = frame_buf_q;
        for (int j = 0; j < N_V; j++) begin
            if (wr_en && (wr_idx == BCNT_W'(j / N_LLRS))) begin
                frame_buf_d[wp_q][j*WIDTH +: WIDTH] = lanes[(j % N_LLRS)*WIDTH +: WIDTH];
            end
        end
    end

    // Completion and consumption never target the same buffer, so both may apply.
    always_comb begin
        full_d = full_q;
        if (complete) begin
            full_d[wp_q] = 1'b1;
        end
        if (consume) begin
            full_d[rp_q] = 1'b0;
        end
        wp_d        = wp_q ^ complete;
        rp_d        = rp_q ^ consume;
        frame_cnt_d = frame_cnt_q + CNT_W'(complete);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RESET_VAL) begin
            state_q        <= StIdle;
            bcnt_q         <= '0;
            frame_buf_q[0] <= '0;
            frame_buf_q[1] <= '0;
            full_q         <= '0;
            wp_q           <= 1'b0;
            rp_q           <= 1'b0;
            frame_cnt_q    <= '0;
            sync_err_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            bcnt_q         <= bcnt_d;
            frame_buf_q[0] <= frame_buf_d[0];
            frame_buf_q[1] <= frame_buf_d[1];
            full_q         <= full_d;
            wp_q           <= wp_d;
            rp_q           <= rp_d;
            frame_cnt_q    <= frame_cnt_d;
            sync_err_q     <= sync_err_d;
        end
    end

endmodule
